// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-side CPU constants: reset/exception vectors, fetch FSM encoding
// and the fetch packet layout used between the sequencer and IF/ID.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
    localparam logic [31:0] EXC_VEC_DEFAULT  = 32'hbfc0_0380;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_ERET = 2'd2,
        SEL_EXC  = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_pkt_t;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next fetch address: exception > eret > branch > pc+4.
// Purely combinational so other units can instantiate the same rule.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
    input  logic        excpt_i,
    input  logic        eret_i,
    input  logic        br_taken_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] br_target_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        redirect_o
);

    pc_sel_e sel;

    always_comb begin
        sel = SEL_SEQ;
        if (excpt_i) begin
            sel = SEL_EXC;
        end else if (eret_i) begin
            sel = SEL_ERET;
        end else if (br_taken_i) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        next_pc_o = pc_i + PC_STEP;
        case (sel)
            SEL_EXC:  next_pc_o = EXC_VEC;
            SEL_ERET: next_pc_o = epc_i;
            SEL_BR:   next_pc_o = br_target_i;
            default:  next_pc_o = pc_i + PC_STEP;
        endcase
    end

    assign redirect_o = (sel != SEL_SEQ);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: one outstanding SRAM read at a time, a single
// packet buffer toward IF/ID, and redirect handling with in-flight cancellation.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_allow_in,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        excpt,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         cancel_q, cancel_d;
    fetch_pkt_t   pkt_q, pkt_d;

    logic [31:0]  mux_pc;
    logic         redirect;
    logic         pc_ok;

    pc_next_mux #(
        .EXC_VEC (EXC_VEC)
    ) u_next_mux (
        .excpt_i     (excpt),
        .eret_i      (eret),
        .br_taken_i  (br_taken),
        .epc_i       (epc),
        .br_target_i (br_target),
        .pc_i        (pc_q),
        .next_pc_o   (mux_pc),
        .redirect_o  (redirect)
    );

    assign pc_ok = word_aligned(pc_q[1:0]);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cancel_d = cancel_q;
        pkt_d    = pkt_q;
        inst_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect) begin
                    pc_d = mux_pc;
                end
            end

            ST_REQ: begin
                if (redirect) begin
                    pc_d = mux_pc;
                end
                if (!pc_ok) begin
                    // Misaligned fetch never reaches SRAM; a redirect retries from REQ.
                    if (!redirect) begin
                        state_d    = ST_HOLD;
                        pkt_d.pc   = pc_q;
                        pkt_d.inst = NOP_INST;
                        pkt_d.adel = 1'b1;
                    end
                end else begin
                    inst_req = 1'b1;
                    if (inst_addr_ok) begin
                        state_d  = ST_WAIT;
                        cancel_d = redirect;
                    end
                end
            end

            ST_WAIT: begin
                if (redirect) begin
                    pc_d = mux_pc;
                end
                if (inst_data_ok) begin
                    cancel_d = 1'b0;
                    if (cancel_q || redirect) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d    = ST_HOLD;
                        pkt_d.pc   = pc_q;
                        pkt_d.inst = inst_rdata;
                        pkt_d.adel = 1'b0;
                    end
                end else if (redirect) begin
                    cancel_d = 1'b1;
                end
            end

            ST_HOLD: begin
                // mux_pc is pc+4 unless a redirect overrides; both leave HOLD.
                if (redirect || id_allow_in) begin
                    pc_d    = mux_pc;
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            cancel_q   <= 1'b0;
            pkt_q.pc   <= RESET_PC;
            pkt_q.inst <= NOP_INST;
            pkt_q.adel <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cancel_q <= cancel_d;
            pkt_q    <= pkt_d;
        end
    end

    assign inst_addr = pc_q;
    assign if_valid  = (state_q == ST_HOLD);
    assign if_pc     = pkt_q.pc;
    assign if_inst   = pkt_q.inst;
    assign if_adel   = pkt_q.adel;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run against a fetch-address reference model and a latency-variable SRAM.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;
    localparam logic [31:0] EXC_PC = 32'hbfc0_0380;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_allow_in;
    logic        br_taken;
    logic [31:0] br_target;
    logic        excpt;
    logic        eret;
    logic [31:0] epc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    int checks   = 0;
    int failures = 0;

    // SRAM responder control (written by the main sequence)
    bit          sram_en  = 1'b0;
    bit          rand_lat = 1'b0;
    int          lat_a    = 1;
    int          lat_d    = 0;
    logic        man_addr_ok = 1'b0;
    logic        man_data_ok = 1'b0;
    logic [31:0] man_rdata   = 32'h0;

    // SRAM responder state (written only by the responder)
    logic        auto_addr_ok = 1'b0;
    logic        auto_data_ok = 1'b0;
    logic [31:0] auto_rdata   = 32'h0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] acc_addr  = 32'h0;
    bit          acc_nx = 1'b0;
    bit          dat_nx = 1'b0;
    int          req_cnt = 0;
    int          dat_cnt = 0;
    int          cur_la  = 0;
    int          cur_ld  = 0;

    assign inst_addr_ok = sram_en ? auto_addr_ok : man_addr_ok;
    assign inst_data_ok = sram_en ? auto_data_ok : man_data_ok;
    assign inst_rdata   = sram_en ? auto_rdata   : man_rdata;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .id_allow_in  (id_allow_in),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .excpt        (excpt),
        .eret         (eret),
        .epc          (epc),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_adel      (if_adel)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h0bad_f00d;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hbfc0_0000;
        t = t | ($urandom & 32'h0000_0ffc);
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    // SRAM model: one transaction in flight, per-transaction latencies
    initial begin
        forever begin
            @(posedge clk);
            if (dat_nx) pend = 1'b0;
            if (acc_nx) begin
                pend      = 1'b1;
                pend_addr = acc_addr;
                dat_cnt   = 0;
                cur_ld    = rand_lat ? int'($urandom_range(0, 3)) : lat_d;
            end
            acc_nx = 1'b0;
            dat_nx = 1'b0;
            #1;
            auto_addr_ok = 1'b0;
            auto_data_ok = 1'b0;
            if (!sram_en || resetn !== 1'b1) begin
                pend    = 1'b0;
                req_cnt = 0;
            end else if (pend) begin
                if (dat_cnt >= cur_ld) begin
                    auto_data_ok = 1'b1;
                    auto_rdata   = mem_word(pend_addr);
                    dat_nx       = 1'b1;
                end
                dat_cnt++;
            end else if (inst_req === 1'b1) begin
                if (req_cnt == 0) cur_la = rand_lat ? int'($urandom_range(0, 2)) : lat_a;
                if (req_cnt >= cur_la) begin
                    auto_addr_ok = 1'b1;
                    acc_nx       = 1'b1;
                    acc_addr     = inst_addr;
                    req_cnt      = 0;
                end else begin
                    req_cnt++;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        resetn      = 1'b0;
        id_allow_in = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'h0;
        excpt       = 1'b0;
        eret        = 1'b0;
        epc         = 32'h0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (if_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        sram_en = 1'b0;
        do_reset();
        resetn = 1'b0;
        #1;
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", inst_req); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        checks++; if (if_pc !== RST_PC) begin failures++; $display("FAIL reset_pc: got %h want %h", if_pc, RST_PC); end
        checks++; if (if_inst !== 32'h0 || if_adel !== 1'b0) begin failures++; $display("FAIL reset_pkt: got inst=%h adel=%b want 0/0", if_inst, if_adel); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL idle_req: got %b want 0", inst_req); end
        @(negedge clk);
        checks++; if (inst_req !== 1'b1 || inst_addr !== RST_PC) begin failures++; $display("FAIL first_req: got req=%b addr=%h want 1/%h", inst_req, inst_addr, RST_PC); end
        @(negedge clk);
        checks++; if (inst_req !== 1'b1 || inst_addr !== RST_PC) begin failures++; $display("FAIL req_hold: got req=%b addr=%h want 1/%h", inst_req, inst_addr, RST_PC); end
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        int got = 0;
        logic [31:0] exp_pc;
        sram_en = 1'b1; rand_lat = 1'b0; lat_a = 1; lat_d = 0;
        do_reset();
        id_allow_in = 1'b1;
        for (int c = 0; c < 60 && got < 3; c++) begin
            @(negedge clk);
            if (if_valid === 1'b1) begin
                exp_pc = RST_PC + 32'(4 * got);
                checks++;
                if (if_pc !== exp_pc || if_inst !== mem_word(exp_pc) || if_adel !== 1'b0) begin
                    failures++;
                    $display("FAIL seq_pkt%0d: got pc=%h inst=%h adel=%b want pc=%h inst=%h adel=0", got, if_pc, if_inst, if_adel, exp_pc, mem_word(exp_pc));
                end
                $display("seq packet %0d pc=%h inst=%h", got, if_pc, if_inst);
                got++;
            end
        end
        checks++; if (got != 3) begin failures++; $display("FAIL seq_count: got %0d packets want 3", got); end
    endtask

    task automatic test_stall();
        bit seen;
        sram_en = 1'b1; rand_lat = 1'b0; lat_a = 1; lat_d = 0;
        do_reset();
        id_allow_in = 1'b1;
        wait_valid(40, seen);
        checks++; if (!seen || if_pc !== RST_PC) begin failures++; $display("FAIL stall_first: got seen=%b pc=%h want 1/%h", seen, if_pc, RST_PC); end
        @(negedge clk);
        wait_valid(40, seen);
        checks++; if (!seen || if_pc !== RST_PC + 32'd4) begin failures++; $display("FAIL stall_second: got seen=%b pc=%h want 1/%h", seen, if_pc, RST_PC + 32'd4); end
        id_allow_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== RST_PC + 32'd4 || if_inst !== mem_word(RST_PC + 32'd4) || inst_req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h inst=%h req=%b want 1/%h/%h/0", i, if_valid, if_pc, if_inst, inst_req, RST_PC + 32'd4, mem_word(RST_PC + 32'd4));
            end
        end
        id_allow_in = 1'b1;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== RST_PC + 32'd8) begin
            failures++;
            $display("FAIL stall_release: got v=%b req=%b addr=%h want 0/1/%h", if_valid, inst_req, inst_addr, RST_PC + 32'd8);
        end
        $display("test_stall done");
    endtask

    task automatic test_branch_wait();
        bit req_seen = 1'b0;
        bit pkt_seen = 1'b0;
        sram_en = 1'b1; rand_lat = 1'b0; lat_a = 0; lat_d = 3;
        do_reset();
        id_allow_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (inst_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL bw_in_wait: got req=%b v=%b want 0/0", inst_req, if_valid); end
        br_taken = 1'b1; br_target = 32'hbfc0_0100;
        @(negedge clk);
        br_taken = 1'b0;
        lat_d = 0;
        for (int c = 0; c < 40 && !pkt_seen; c++) begin
            if (inst_req === 1'b1 && !req_seen) begin
                req_seen = 1'b1;
                checks++; if (inst_addr !== 32'hbfc0_0100) begin failures++; $display("FAIL bw_req_addr: got %h want bfc00100", inst_addr); end
            end
            if (if_valid === 1'b1) begin
                pkt_seen = 1'b1;
                checks++;
                if (if_pc !== 32'hbfc0_0100 || if_inst !== mem_word(32'hbfc0_0100)) begin
                    failures++;
                    $display("FAIL bw_pkt: got pc=%h inst=%h want bfc00100/%h", if_pc, if_inst, mem_word(32'hbfc0_0100));
                end
            end
            @(negedge clk);
        end
        checks++; if (!req_seen || !pkt_seen) begin failures++; $display("FAIL bw_timeout: got req=%b pkt=%b want 1/1", req_seen, pkt_seen); end
        $display("test_branch_wait done");
    endtask

    task automatic test_priority();
        bit seen;
        sram_en = 1'b1; rand_lat = 1'b0; lat_a = 1; lat_d = 0;
        do_reset();
        id_allow_in = 1'b0;
        wait_valid(40, seen);
        excpt = 1'b1; br_taken = 1'b1; br_target = 32'hbfc0_0100;
        @(negedge clk);
        excpt = 1'b0; br_taken = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== EXC_PC) begin
            failures++;
            $display("FAIL exc_over_br: got v=%b req=%b addr=%h want 0/1/%h", if_valid, inst_req, inst_addr, EXC_PC);
        end
        wait_valid(40, seen);
        checks++; if (!seen || if_pc !== EXC_PC) begin failures++; $display("FAIL exc_pkt: got seen=%b pc=%h want 1/%h", seen, if_pc, EXC_PC); end
        eret = 1'b1; epc = 32'h8000_0040; br_taken = 1'b1; br_target = 32'hbfc0_0100;
        @(negedge clk);
        eret = 1'b0; br_taken = 1'b0;
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0040) begin
            failures++;
            $display("FAIL eret_over_br: got req=%b addr=%h want 1/80000040", inst_req, inst_addr);
        end
        $display("test_priority done");
    endtask

    task automatic test_eret_misaligned();
        bit seen;
        sram_en = 1'b1; rand_lat = 1'b0; lat_a = 1; lat_d = 0;
        do_reset();
        id_allow_in = 1'b0;
        wait_valid(40, seen);
        eret = 1'b1; epc = 32'h8000_0002;
        @(negedge clk);
        eret = 1'b0;
        checks++; if (inst_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL adel_noreq: got req=%b v=%b want 0/0", inst_req, if_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h8000_0002 || if_adel !== 1'b1 || if_inst !== 32'h0 || inst_req !== 1'b0) begin
                failures++;
                $display("FAIL adel_pkt%0d: got v=%b pc=%h adel=%b inst=%h req=%b want 1/80000002/1/0/0", i, if_valid, if_pc, if_adel, if_inst, inst_req);
            end
        end
        $display("test_eret_misaligned done");
    endtask

    task automatic test_reset_mid();
        sram_en = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b0; man_rdata = 32'h0;
        do_reset();
        @(negedge clk);
        man_addr_ok = 1'b1;
        @(negedge clk);
        man_addr_ok = 1'b0;
        checks++; if (inst_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL rm_wait: got req=%b v=%b want 0/0", inst_req, if_valid); end
        resetn = 1'b0;
        #1;
        checks++;
        if (inst_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== RST_PC || if_inst !== 32'h0 || if_adel !== 1'b0) begin
            failures++;
            $display("FAIL rm_async: got req=%b v=%b pc=%h inst=%h adel=%b want 0/0/%h/0/0", inst_req, if_valid, if_pc, if_inst, if_adel, RST_PC);
        end
        @(negedge clk);
        resetn = 1'b1; man_data_ok = 1'b1; man_rdata = 32'hdead_beef;
        @(negedge clk);
        man_data_ok = 1'b0;
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== RST_PC || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_stale: got req=%b addr=%h v=%b want 1/%h/0", inst_req, inst_addr, if_valid, RST_PC);
        end
        man_addr_ok = 1'b1;
        @(negedge clk);
        man_addr_ok = 1'b0; man_data_ok = 1'b1; man_rdata = mem_word(RST_PC);
        @(negedge clk);
        man_data_ok = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== RST_PC || if_inst !== mem_word(RST_PC)) begin
            failures++;
            $display("FAIL rm_first_pkt: got v=%b pc=%h inst=%h want 1/%h/%h", if_valid, if_pc, if_inst, RST_PC, mem_word(RST_PC));
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [31:0] mpc = RST_PC;
        logic [31:0] p_tgt = 32'h0;
        logic [31:0] exp_inst;
        logic        exp_adel;
        bit          p_redir = 1'b0;
        bit          p_cons = 1'b0;
        int          consumed = 0;
        int          fails_here = 0;
        sram_en = 1'b1; rand_lat = 1'b1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (p_redir) mpc = p_tgt;
            else if (p_cons) begin mpc = mpc + 32'd4; consumed++; end
            if (if_valid === 1'b1) begin
                exp_adel = (mpc[1:0] != 2'b00);
                exp_inst = exp_adel ? 32'h0 : mem_word(mpc);
                checks++;
                if (if_pc !== mpc || if_inst !== exp_inst || if_adel !== exp_adel) begin
                    failures++; fails_here++;
                    if (fails_here < 10) $display("FAIL rnd_pkt c=%0d: got pc=%h inst=%h adel=%b want %h/%h/%b", c, if_pc, if_inst, if_adel, mpc, exp_inst, exp_adel);
                end
            end
            if (inst_req === 1'b1) begin
                checks++;
                if (inst_addr !== mpc || mpc[1:0] != 2'b00 || pend) begin
                    failures++; fails_here++;
                    if (fails_here < 10) $display("FAIL rnd_req c=%0d: got addr=%h outstanding=%b want %h aligned/0", c, inst_addr, pend, mpc);
                end
            end
            id_allow_in = ($urandom_range(0, 3) != 0);
            excpt       = ($urandom_range(0, 29) == 0);
            eret        = ($urandom_range(0, 19) == 0);
            br_taken    = ($urandom_range(0, 11) == 0);
            epc         = rand_target();
            br_target   = rand_target();
            p_redir = excpt || eret || br_taken;
            p_tgt   = excpt ? EXC_PC : (eret ? epc : br_target);
            p_cons  = (if_valid === 1'b1) && id_allow_in;
        end
        excpt = 1'b0; eret = 1'b0; br_taken = 1'b0;
        checks++; if (consumed < 50) begin failures++; $display("FAIL rnd_progress: got %0d packets want >=50", consumed); end
        $display("test_random done consumed=%0d", consumed);
    endtask

    initial begin
        resetn = 1'b0; id_allow_in = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        excpt = 1'b0; eret = 1'b0; epc = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_wait();
        test_priority();
        test_eret_misaligned();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc00000, first fetch address after reset.
REQ-002 Parameter EXC_VEC, default 32'hbfc00380, exception redirect target.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 id_allow_in  input  1  ID can accept an instruction this cycle (IF/ID write enable).
REQ-006 br_taken  input  1  taken branch/jump resolved in ID, one-cycle pulse.
REQ-007 br_target  input  32  branch/jump target, valid with br_taken.
REQ-008 excpt  input  1  exception commit pulse from later stage.
REQ-009 eret  input  1  ERET commit pulse.
REQ-010 epc  input  32  return address, valid with eret.
REQ-011 inst_req  output  1  instruction SRAM request.
REQ-012 inst_addr  output  32  request address, word aligned.
REQ-013 inst_addr_ok  input  1  SRAM accepted request this cycle.
REQ-014 inst_data_ok  input  1  SRAM read data valid this cycle.
REQ-015 inst_rdata  input  32  SRAM read data.
REQ-016 if_valid  output  1  fetch packet valid toward IF/ID (IRWrite).
REQ-017 if_pc  output  32  PC of the packet.
REQ-018 if_inst  output  32  instruction of the packet.
REQ-019 if_adel  output  1  packet carries address-error-on-fetch.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, HOLD; reset state IDLE.
REQ-021 IDLE -> REQ the first cycle after reset release; pc register = RESET_PC.
REQ-022 REQ: inst_req=1, inst_addr=pc; on inst_addr_ok -> WAIT; inst_req stays high, inst_addr stable, until addr_ok.
REQ-023 WAIT: on inst_data_ok latch inst_rdata into packet buffer -> HOLD.
REQ-024 HOLD: if_valid=1; when id_allow_in=1 the packet is consumed, pc advances, state -> REQ in the same edge.
REQ-025 Next pc priority: excpt (EXC_VEC) > eret (epc) > br_taken (br_target) > pc+4; sum wraps modulo 2^32.
REQ-026 Redirect in REQ before addr_ok: inst_addr updates next cycle; no stale request is issued.
REQ-027 Redirect in WAIT: cancel flag set; returning data discarded (no if_valid); then REQ with redirect target.
REQ-028 Redirect in HOLD: buffered packet dropped, if_valid low next cycle, REQ with redirect target.
REQ-029 Redirect coincident with data_ok: data discarded, redirect wins.
REQ-030 Misaligned pc (pc[1:0]!=0): no SRAM request; go directly to HOLD with if_inst=0, if_adel=1, if_pc=pc.
REQ-031 if_valid high only in HOLD; if_pc/if_inst/if_adel stable while if_valid and id_allow_in=0.
REQ-032 At most one outstanding SRAM transaction; inst_req low in WAIT and HOLD.
REQ-033 Redirect pulses arriving in consecutive cycles: the last one before the next REQ issue determines the target.

Reset
REQ-034 Async assert: state=IDLE, pc=RESET_PC, cancel=0, inst_req=0, if_valid=0, if_pc=RESET_PC, if_inst=0, if_adel=0.
REQ-035 Reset mid-transaction: outstanding data_ok after release ignored while cancel-free IDLE; first request is to RESET_PC.

Structure
REQ-036 FSM state encoding, RESET_PC and EXC_VEC defaults live in the shared CPU constants package.
REQ-037 One sub-module, pc_next_mux: combinational priority select of REQ-025, reused by the exception unit for verification.

Verification
REQ-038 Reset release, addr_ok and data_ok each one cycle later, id_allow_in=1 -> packets at PCs bfc00000, bfc00004, bfc00008 in order.
REQ-039 id_allow_in=0 for 5 cycles in HOLD -> if_valid, if_pc=bfc00004, if_inst held; no inst_req issued.
REQ-040 br_taken with br_target=bfc00100 during WAIT -> returned data dropped, next inst_addr=bfc00100.
REQ-041 excpt and br_taken same cycle -> next inst_addr=bfc00380.
REQ-042 eret with epc=80000002 -> no inst_req, if_valid=1, if_pc=80000002, if_adel=1, if_inst=0.
REQ-043 resetn low during WAIT, data_ok after release -> ignored; first packet at bfc00000.
